// File: rtl/fpu_add_seq_if.sv
// fpu_add_seq_if: request/result bundle for the multicycle FP adder
//   start       request, sampled only while the adder is idle
//   a, b        IEEE-754 single-layout operands
//   busy        high while an operation is in flight
//   done        one-cycle completion pulse
//   result      packed sum, held until the next done
interface fpu_add_seq_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                    start;
    logic [EXP_W+FRAC_W:0]   a;
    logic [EXP_W+FRAC_W:0]   b;
    logic                    busy;
    logic                    done;
    logic [EXP_W+FRAC_W:0]   result;
    modport master (output start, a, b, input busy, done, result);
    modport slave  (input start, a, b, output busy, done, result);
endinterface

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: positive-only truncating FP adder with a one-bit-per-cycle alignment shifter
//   clk         rising-edge clock
//   reset       synchronous active-high reset, aborts any operation
//   bus         slave side of fpu_add_seq_if (start/a/b in, busy/done/result out)
module fpu_add_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    fpu_add_seq_if.slave      bus
);
    localparam int M = FRAC_W + 1;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t                  state_q, state_d;
    logic [EXP_W-1:0]        exp_q, exp_d, cnt_q, cnt_d;
    logic [M-1:0]            big_q, big_d, small_q, small_d;
    logic [M:0]              sum_q, sum_d;
    logic [EXP_W+FRAC_W:0]   result_q, result_d;
    logic                    done_q, done_d;
    logic [EXP_W-1:0]        ea, eb;
    logic [M-1:0]            ma, mb;
    logic                    a_ge;
    assign ea   = bus.a[FRAC_W +: EXP_W];
    assign eb   = bus.b[FRAC_W +: EXP_W];
    assign ma   = {1'b1, bus.a[FRAC_W-1:0]};
    assign mb   = {1'b1, bus.b[FRAC_W-1:0]};
    assign a_ge = ea >= eb;
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        big_d    = big_q;
        small_d  = small_q;
        sum_d    = sum_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                exp_d   = a_ge ? ea : eb;
                big_d   = a_ge ? ma : mb;
                small_d = a_ge ? mb : ma;
                cnt_d   = a_ge ? ea - eb : eb - ea;
                state_d = ALIGN;
            end
            // Stops early once the small operand has been shifted out entirely.
            ALIGN: if (cnt_q == '0 || small_q == '0) state_d = ADD;
            else begin
                small_d = small_q >> 1;
                cnt_d   = cnt_q - 1'b1;
            end
            ADD: begin
                sum_d   = {1'b0, big_q} + {1'b0, small_q};
                state_d = NORM;
            end
            // Result is registered here so it is already valid during the DONE cycle.
            // A carry out of exponent 254 saturates to +infinity.
            NORM: begin
                result_d = !sum_q[M] ? {1'b0, exp_q, sum_q[FRAC_W-1:0]} :
                           exp_q == {{(EXP_W-1){1'b1}}, 1'b0} ? {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                           {1'b0, exp_q + 1'b1, sum_q[FRAC_W:1]};
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            cnt_q    <= '0;
            big_q    <= '0;
            small_q  <= '0;
            sum_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            big_q    <= big_d;
            small_q  <= small_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
    assign bus.busy   = state_q != IDLE;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_fpu_add_seq.sv
// tb_fpu_add_seq: directed and randomized checks of fpu_add_seq against an arithmetic reference
module tb_fpu_add_seq;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    fpu_add_seq_if bus ();
    fpu_add_seq dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: align by a plain right shift of the full distance, add, renormalize once.
    task automatic model(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] r, output int lat);
        int ea, eb, d, e;
        longint ma, mb, big, sml, sum;
        logic [31:0] s32;
        ea = int'(xa[30:23]);
        eb = int'(xb[30:23]);
        ma = longint'(1 << 23) + longint'(xa[22:0]);
        mb = longint'(1 << 23) + longint'(xb[22:0]);
        big = (ea >= eb) ? ma : mb;
        sml = (ea >= eb) ? mb : ma;
        e   = (ea >= eb) ? ea : eb;
        d   = (ea >= eb) ? ea - eb : eb - ea;
        sml = (d >= 24) ? 0 : sml >> d;
        lat = ((d < 24) ? d : 24) + 4;
        sum = big + sml;
        if (sum >= longint'(1 << 24)) begin
            sum = sum / 2;
            e   = e + 1;
        end
        s32 = 32'(sum);
        r = (e == 255) ? 32'h7F800000 : {1'b0, 8'(e), s32[22:0]};
    endtask

    // Latency counts clock edges from the start edge (edge 1) to the edge after which done is seen.
    task automatic run(input logic [31:0] xa, input logic [31:0] xb,
                       output int lat, output logic [31:0] res, output int busy_n);
        bus.a = xa;
        bus.b = xb;
        bus.start = 1'b1;
        lat = 0;
        busy_n = 0;
        res = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = i;
                res = bus.result;
                break;
            end
        end
        @(posedge clk); #1;
        chk("back_to_idle", 64'(bus.busy), 64'd0);
    endtask

    logic [31:0] dir_a [5] = '{32'h3F800000, 32'h3FC00000, 32'h3E800000, 32'h3F800000, 32'h7F7FFFFF};
    logic [31:0] dir_b [5] = '{32'h3F800000, 32'h3E800000, 32'h3FC00000, 32'h30800000, 32'h7F7FFFFF};
    logic [31:0] dir_r [5] = '{32'h40000000, 32'h3FE00000, 32'h3FE00000, 32'h3F800000, 32'h7F800000};
    int          dir_l [5] = '{4, 6, 6, 28, 4};

    initial begin
        int lat, busy_n, nd, elat, ea, eb;
        logic [31:0] res, eres, xa, xb;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(dir_a[i], dir_b[i], lat, res, busy_n);
            chk($sformatf("dir%0d_result", i), 64'(res), 64'(dir_r[i]));
            chk($sformatf("dir%0d_latency", i), 64'(lat), 64'(dir_l[i]));
            chk($sformatf("dir%0d_busy_cycles", i), 64'(busy_n), 64'(dir_l[i]));
        end

        // start held high; operands changed right after the start edge
        bus.a = 32'h3FC00000;
        bus.b = 32'h3E800000;
        bus.start = 1'b1;
        nd = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.a = 32'h3F800000;
                bus.b = 32'h3F800000;
            end
            if (bus.done) begin
                nd++;
                lat = i;
                res = bus.result;
                break;
            end
        end
        chk("hold_result", 64'(res), 64'h3FE00000);
        chk("hold_latency", 64'(lat), 64'd6);
        chk("hold_done_count", 64'(nd), 64'd1);
        @(posedge clk); #1;
        chk("hold_ignored_in_done", 64'(bus.busy), 64'd0);
        chk("hold_no_second_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        chk("hold_accept_from_idle", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        lat = 0;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                res = bus.result;
                break;
            end
        end
        chk("hold2_result", 64'(res), 64'h40000000);
        chk("hold2_latency", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // reset during the long alignment of the diff=30 case
        bus.a = 32'h3F800000;
        bus.b = 32'h30800000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        run(32'h3F800000, 32'h3F800000, lat, res, busy_n);
        chk("after_abort_result", 64'(res), 64'h40000000);
        chk("after_abort_latency", 64'(lat), 64'd4);

        // randomized operands: half with nearby exponents to exercise carries
        for (int i = 0; i < 40; i++) begin
            xa = $urandom;
            xb = $urandom;
            ea = int'($urandom_range(0, 254));
            eb = (i % 2 == 0) ? int'($urandom_range(0, 254)) : ea + int'($urandom_range(0, 6)) - 3;
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            xa[30:23] = 8'(ea);
            xb[30:23] = 8'(eb);
            model(xa, xb, eres, elat);
            run(xa, xb, lat, res, busy_n);
            chk($sformatf("rnd%0d_result a=%h b=%h", i, xa, xb), 64'(res), 64'(eres));
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
